// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main controller: FETCH->DECODE->EXEC->[MEM]->[WB] with memory
// req/ready handshakes, bounded-wait timeout trap and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int WAIT_MAX = 16,
  parameter int RET_W    = 32,
  parameter int ALU_OP_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic                branch_taken,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_sel,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic                trap,
  output logic [RET_W-1:0]    instret,
  output logic [2:0]          state_o
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [6:0]       op_q, op_d;
  logic             trap_q, trap_d;
  logic [RET_W-1:0] instret_q, instret_d;

  logic waiting, wait_last, legal, retire;
  logic                alu_src_x;
  logic [ALU_OP_W-1:0] alu_op_x;

  assign waiting   = ((state_q == S_FETCH) && !imem_ready) || ((state_q == S_MEM) && !dmem_ready);
  assign wait_last = (wait_q == CNT_W'(WAIT_MAX - 1));
  assign legal     = (opcode == OP_R)      || (opcode == OP_LOAD) || (opcode == OP_STORE) ||
                     (opcode == OP_BRANCH) || (opcode == OP_IMM)  || (opcode == OP_LUI)   ||
                     (opcode == OP_JAL)    || (opcode == OP_JALR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      op_q      <= '0;
      trap_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      trap_q    <= trap_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem_ready) state_d = S_DECODE;
                else if (wait_last) state_d = S_TRAP;
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (op_q)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BRANCH:         state_d = S_FETCH;
          default:           state_d = S_WB;
        endcase
      end
      S_MEM:    if (dmem_ready) state_d = (op_q == OP_LOAD) ? S_WB : S_FETCH;
                else if (wait_last) state_d = S_TRAP;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Counter only runs while a request is stalled in place; any state change clears it.
  always_comb begin
    retire    = ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) &&
                (state_d == S_FETCH);
    wait_d    = (waiting && (state_d == state_q)) ? wait_q + CNT_W'(1) : '0;
    op_d      = (state_q == S_DECODE) ? opcode : op_q;
    trap_d    = trap_q | (state_d == S_TRAP);
    instret_d = retire ? instret_q + RET_W'(1) : instret_q;
  end

  always_comb begin
    alu_src_x = 1'b0;
    alu_op_x  = ALU_OP_W'(2'b00);
    case (op_q)
      OP_IMM, OP_LOAD, OP_STORE, OP_JALR: begin alu_src_x = 1'b1; alu_op_x = ALU_OP_W'(2'b01); end
      OP_LUI:    begin alu_src_x = 1'b1; alu_op_x = ALU_OP_W'(2'b11); end
      OP_BRANCH: begin alu_src_x = 1'b0; alu_op_x = ALU_OP_W'(2'b10); end
      default:   ;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = '0;
    reg_write  = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        pc_write = imem_ready;
      end
      S_EXEC: begin
        alu_src = alu_src_x;
        alu_op  = alu_op_x;
        case (op_q)
          OP_BRANCH: begin pc_write = branch_taken; pc_sel = 2'b01; end
          OP_JAL:    begin pc_write = 1'b1;         pc_sel = 2'b10; end
          OP_JALR:   begin pc_write = 1'b1;         pc_sel = 2'b11; end
          default:   ;
        endcase
      end
      S_MEM: begin
        alu_src   = alu_src_x;
        alu_op    = alu_op_x;
        dmem_req  = 1'b1;
        mem_read  = (op_q == OP_LOAD);
        mem_write = (op_q == OP_STORE);
      end
      S_WB: begin
        alu_src    = alu_src_x;
        alu_op     = alu_op_x;
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LOAD);
      end
      default: ;
    endcase
  end

  assign trap    = trap_q;
  assign instret = instret_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (RET_W=4 build so counter wrap is reachable).
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       branch_taken, imem_ready, dmem_ready;
  logic       imem_req, dmem_req, ir_write, pc_write, mem_read, mem_write;
  logic       mem_to_reg, alu_src, reg_write, trap;
  logic [1:0] pc_sel, alu_op;
  logic [3:0] instret;
  logic [2:0] state_o;
  logic [13:0] outs;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.WAIT_MAX(16), .RET_W(4), .ALU_OP_W(2)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_sel(pc_sel),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .alu_op(alu_op), .reg_write(reg_write), .trap(trap),
    .instret(instret), .state_o(state_o)
  );

  // {imem_req,dmem_req,ir_write,pc_write,pc_sel,mem_read,mem_write,mem_to_reg,alu_src,alu_op,reg_write,trap}
  assign outs = {imem_req, dmem_req, ir_write, pc_write, pc_sel, mem_read, mem_write,
                 mem_to_reg, alu_src, alu_op, reg_write, trap};

  localparam logic [13:0] O_IDLE  = 14'b0_0_0_0_00_0_0_0_0_00_0_0;
  localparam logic [13:0] O_FHIT  = 14'b1_0_1_1_00_0_0_0_0_00_0_0;
  localparam logic [13:0] O_FWAIT = 14'b1_0_0_0_00_0_0_0_0_00_0_0;
  localparam logic [13:0] O_TRAP  = 14'b0_0_0_0_00_0_0_0_0_00_0_1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: drive, check mid-cycle, advance to the next falling edge.
  task automatic step(input string tag, input logic ir, input logic dr, input logic bt,
                      input logic [2:0] es, input logic [13:0] eo);
    imem_ready = ir; dmem_ready = dr; branch_taken = bt;
    #1;
    check_eq({tag, ".st"}, {29'd0, state_o}, {29'd0, es});
    check_eq({tag, ".out"}, {18'd0, outs}, {18'd0, eo});
    @(negedge clk);
  endtask

  task automatic fetch_dec(input string tag, input logic [6:0] op);
    opcode = op;
    step({tag, ".F"}, 1'b1, 1'b0, 1'b0, 3'd0, O_FHIT);
    step({tag, ".D"}, 1'b1, 1'b0, 1'b0, 3'd1, O_IDLE);
  endtask

  task automatic do_reset();
    imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; opcode = '0; branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst.st", {29'd0, state_o}, 32'd0);
    check_eq("rst.trap", {31'd0, trap}, 32'd0);
    check_eq("rst.ret", {28'd0, instret}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // R-type add with no waits
    fetch_dec("add", 7'b0110011);
    step("add.E", 1'b1, 1'b1, 1'b0, 3'd2, O_IDLE);
    check_eq("add.ret0", {28'd0, instret}, 32'd0);
    step("add.W", 1'b1, 1'b1, 1'b0, 3'd4, 14'b0_0_0_0_00_0_0_0_0_00_1_0);
    check_eq("add.ret", {28'd0, instret}, 32'd1);

    // Load with dmem_ready held off for three cycles
    fetch_dec("lw", 7'b0000011);
    step("lw.E", 1'b0, 1'b0, 1'b0, 3'd2, 14'b0_0_0_0_00_0_0_0_1_01_0_0);
    for (int i = 0; i < 3; i++)
      step("lw.Mw", 1'b0, 1'b0, 1'b0, 3'd3, 14'b0_1_0_0_00_1_0_0_1_01_0_0);
    step("lw.M", 1'b0, 1'b1, 1'b0, 3'd3, 14'b0_1_0_0_00_1_0_0_1_01_0_0);
    step("lw.W", 1'b0, 1'b0, 1'b0, 3'd4, 14'b0_0_0_0_00_0_0_1_1_01_1_0);
    check_eq("lw.ret", {28'd0, instret}, 32'd2);

    fetch_dec("beqT", 7'b1100011);
    step("beqT.E", 1'b0, 1'b0, 1'b1, 3'd2, 14'b0_0_0_1_01_0_0_0_0_10_0_0);
    check_eq("beqT.ret", {28'd0, instret}, 32'd3);
    fetch_dec("beqN", 7'b1100011);
    step("beqN.E", 1'b0, 1'b0, 1'b0, 3'd2, 14'b0_0_0_0_01_0_0_0_0_10_0_0);
    check_eq("beqN.ret", {28'd0, instret}, 32'd4);

    // OP-IMM whose fetch gets ready on the last allowed waiting cycle
    opcode = 7'b0010011;
    for (int i = 0; i < 15; i++)
      step("late.Fw", 1'b0, 1'b0, 1'b0, 3'd0, O_FWAIT);
    step("late.F", 1'b1, 1'b0, 1'b0, 3'd0, O_FHIT);
    step("late.D", 1'b0, 1'b0, 1'b0, 3'd1, O_IDLE);
    step("late.E", 1'b0, 1'b0, 1'b0, 3'd2, 14'b0_0_0_0_00_0_0_0_1_01_0_0);
    step("late.W", 1'b0, 1'b0, 1'b0, 3'd4, 14'b0_0_0_0_00_0_0_0_1_01_1_0);
    check_eq("late.ret", {28'd0, instret}, 32'd5);

    fetch_dec("sw", 7'b0100011);
    step("sw.E", 1'b0, 1'b0, 1'b0, 3'd2, 14'b0_0_0_0_00_0_0_0_1_01_0_0);
    step("sw.M", 1'b0, 1'b1, 1'b0, 3'd3, 14'b0_1_0_0_00_0_1_0_1_01_0_0);
    check_eq("sw.ret", {28'd0, instret}, 32'd6);

    fetch_dec("jal", 7'b1101111);
    step("jal.E", 1'b0, 1'b0, 1'b0, 3'd2, 14'b0_0_0_1_10_0_0_0_0_00_0_0);
    step("jal.W", 1'b0, 1'b0, 1'b0, 3'd4, 14'b0_0_0_0_00_0_0_0_0_00_1_0);
    fetch_dec("jalr", 7'b1100111);
    step("jalr.E", 1'b0, 1'b0, 1'b0, 3'd2, 14'b0_0_0_1_11_0_0_0_1_01_0_0);
    step("jalr.W", 1'b0, 1'b0, 1'b0, 3'd4, 14'b0_0_0_0_00_0_0_0_1_01_1_0);
    fetch_dec("lui", 7'b0110111);
    step("lui.E", 1'b0, 1'b0, 1'b0, 3'd2, 14'b0_0_0_0_00_0_0_0_1_11_0_0);
    step("lui.W", 1'b0, 1'b0, 1'b0, 3'd4, 14'b0_0_0_0_00_0_0_0_1_11_1_0);
    check_eq("lui.ret", {28'd0, instret}, 32'd9);

    // Fill the 4-bit counter to 15, then wrap
    for (int i = 0; i < 6; i++) begin
      fetch_dec("fill", 7'b1100011);
      step("fill.E", 1'b0, 1'b0, 1'b0, 3'd2, 14'b0_0_0_0_01_0_0_0_0_10_0_0);
    end
    check_eq("fill.ret", {28'd0, instret}, 32'd15);
    fetch_dec("wrap", 7'b1100011);
    step("wrap.E", 1'b0, 1'b0, 1'b0, 3'd2, 14'b0_0_0_0_01_0_0_0_0_10_0_0);
    check_eq("wrap.ret", {28'd0, instret}, 32'd0);

    fetch_dec("add2", 7'b0110011);
    step("add2.E", 1'b0, 1'b0, 1'b0, 3'd2, O_IDLE);
    step("add2.W", 1'b0, 1'b0, 1'b0, 3'd4, 14'b0_0_0_0_00_0_0_0_0_00_1_0);
    check_eq("add2.ret", {28'd0, instret}, 32'd1);

    // Asynchronous reset while a load sits in MEM
    fetch_dec("lwr", 7'b0000011);
    step("lwr.E", 1'b0, 1'b0, 1'b0, 3'd2, 14'b0_0_0_0_00_0_0_0_1_01_0_0);
    step("lwr.M", 1'b0, 1'b0, 1'b0, 3'd3, 14'b0_1_0_0_00_1_0_0_1_01_0_0);
    rst = 1'b1;
    #1;
    check_eq("lwr.rst.st", {29'd0, state_o}, 32'd0);
    check_eq("lwr.rst.ret", {28'd0, instret}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fetch timeout: 16 stalled cycles then TRAP
    for (int i = 0; i < 16; i++)
      step("tmo.Fw", 1'b0, 1'b0, 1'b0, 3'd0, O_FWAIT);
    for (int i = 0; i < 3; i++)
      step("tmo.T", 1'b1, 1'b1, 1'b1, 3'd5, O_TRAP);

    do_reset();
    fetch_dec("add3", 7'b0110011);
    step("add3.E", 1'b0, 1'b0, 1'b0, 3'd2, O_IDLE);
    step("add3.W", 1'b0, 1'b0, 1'b0, 3'd4, 14'b0_0_0_0_00_0_0_0_0_00_1_0);

    // Illegal opcode traps and holds with instret frozen
    fetch_dec("ill", 7'b1111111);
    for (int i = 0; i < 20; i++)
      step("ill.T", i[0], ~i[0], i[1], 3'd5, O_TRAP);
    check_eq("ill.ret", {28'd0, instret}, 32'd1);
    do_reset();
    step("post.F", 1'b0, 1'b0, 1'b0, 3'd0, O_FWAIT);
    check_eq("post.ret", {28'd0, instret}, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
